mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between the fetch stage (instruction reads) and the load/store unit (data reads and writes).
- Load/store has priority by default. A streak limiter guarantees fetch forward progress.
- A fetch flush (branch taken or debug PC write) cancels delivery of any in-flight fetch response.
- One outstanding memory transaction at a time. The block sits between fetch/LSU and the memory wrapper.

---
 rtl/mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and the LSU,
//               one outstanding transaction, LSU priority with a fetch streak
//               limiter. Optional watchdog enabled by defining ARB_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        error_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  localparam logic       OWNER_LS   = 1'b0;
  localparam logic       OWNER_IF   = 1'b1;
  localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

  if (DATA_STREAK_MAX < 1 || DATA_STREAK_MAX > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("mem_port_arbiter: DATA_STREAK_MAX or TIMEOUT_CYCLES out of range");
  end

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        kill_q, kill_d;
  logic [3:0]  streak_q, streak_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        sel_ls;
  logic        sel_if;
  logic        timeout_hit;
  logic        rsp_fire;

  // Grants only in IDLE with run high; reset also masks them so outputs stay quiet.
  always_comb begin
    sel_ls = 1'b0;
    sel_if = 1'b0;
    if (state_q == ST_IDLE && run && !reset) begin
      sel_ls = ls_req_i && !(if_req_i && streak_q == STREAK_MAX);
      sel_if = if_req_i && !sel_ls;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    kill_d      = kill_q;
    streak_d    = streak_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (!if_req_i) begin
          streak_d = 4'd0;
        end
        if (sel_ls) begin
          owner_d     = OWNER_LS;
          mem_we_d    = ls_we_i;
          mem_be_d    = ls_be_i;
          mem_addr_d  = ls_addr_i;
          mem_wdata_d = ls_wdata_i;
          state_d     = ST_REQ;
          if (if_req_i && streak_q != 4'hF) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (sel_if) begin
          owner_d     = OWNER_IF;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'hF;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = 32'h0;
          state_d     = ST_REQ;
          streak_d    = 4'd0;
          kill_d      = flush_i;
        end
      end
      ST_REQ: begin
        if (flush_i && owner_q == OWNER_IF) begin
          kill_d = 1'b1;
        end
        if (mem_gnt_i) begin
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (flush_i && owner_q == OWNER_IF) begin
          kill_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          state_d = ST_IDLE;
          kill_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (timeout_hit) begin
      state_d = ST_IDLE;
      kill_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_LS;
      kill_q      <= 1'b0;
      streak_q    <= 4'd0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      streak_q    <= streak_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;

  // A real response on the last allowed cycle takes precedence over the watchdog.
  assign timeout_hit = (state_q != ST_IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) &&
                       !(state_q == ST_RSP && mem_rvalid_i);

  always_comb begin
    wd_d    = '0;
    error_d = error_q;
    if (state_q != ST_IDLE) begin
      wd_d = wd_q + 1'b1;
    end
    if (timeout_hit) begin
      wd_d    = '0;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error_o     = 1'b0;
`endif

  assign rsp_fire    = (state_q == ST_RSP && mem_rvalid_i) || timeout_hit;

  assign if_gnt_o    = sel_if;
  assign ls_gnt_o    = sel_ls;
  assign if_rvalid_o = rsp_fire && owner_q == OWNER_IF && !kill_q;
  assign ls_rvalid_o = rsp_fire && owner_q == OWNER_LS;
  assign if_rdata_o  = timeout_hit ? 32'h0 : mem_rdata_i;
  assign ls_rdata_o  = timeout_hit ? 32'h0 : mem_rdata_i;

  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: scoreboard bench with a behavioural memory responder
// and autonomous fetch/LSU request agents.
module tb_mem_port_arbiter;

  localparam int unsigned STREAK = 4;
  localparam int unsigned TMO    = 8;

  logic        clk = 1'b0;
  logic        reset, run, flush_i;
  logic        if_req_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        busy_o, error_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_STREAK_MAX(STREAK), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .error_o(error_o)
  );

  typedef struct {
    bit          is_if;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          killed;
  } txn_t;

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ls_op_t;

  txn_t        sb[$];
  logic [31:0] if_todo[$];
  ls_op_t      ls_todo[$];
  bit          grant_log[$];
  logic [31:0] ref_mem [bit [31:0]];
  logic [31:0] dev_mem [bit [31:0]];

  int n_err = 0;
  int n_chk = 0;
  int gnt_delay = 0;
  int rsp_delay = 0;
  bit hang = 1'b0;
  bit tmo_window = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic ls_push(input bit we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
    ls_op_t op;
    op.we = we; op.be = be; op.addr = addr; op.wdata = wdata;
    ls_todo.push_back(op);
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (if_todo.size() == 0 && ls_todo.size() == 0 && sb.size() == 0 && !busy_o);
    end
    check(tag, 32'(done), 32'd1);
  endtask

  // Request agents: hold the head of each queue until it is granted.
  initial begin
    if_req_i = 0; if_addr_i = 0;
    ls_req_i = 0; ls_we_i = 0; ls_be_i = 0; ls_addr_i = 0; ls_wdata_i = 0;
    forever begin
      @(posedge clk);
      #1;
      if (if_todo.size() != 0) begin
        if_req_i = 1'b1; if_addr_i = if_todo[0];
      end else begin
        if_req_i = 1'b0;
      end
      if (ls_todo.size() != 0) begin
        ls_req_i = 1'b1; ls_we_i = ls_todo[0].we; ls_be_i = ls_todo[0].be;
        ls_addr_i = ls_todo[0].addr; ls_wdata_i = ls_todo[0].wdata;
      end else begin
        ls_req_i = 1'b0;
      end
    end
  end

  // Memory responder with programmable grant and response latency.
  initial begin
    logic [31:0] rsp_data;
    int gw, rw;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    gw = 0; rw = 0; rsp_data = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = reset ? 32'h0 : 32'hBADC_0DE5;
      if (reset || !busy_o) begin
        gw = 0; rw = 0;
      end else if (mem_req_o) begin
        if (!hang && gw >= gnt_delay) begin
          mem_gnt_i = 1'b1; gw = 0; rw = 0;
          if (mem_we_o) dev_mem[mem_addr_o] = merge(dev_read(mem_addr_o), mem_wdata_o, mem_be_o);
          else rsp_data = dev_read(mem_addr_o);
        end else begin
          gw++;
        end
      end else begin
        if (rw >= rsp_delay) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = rsp_data;
        end else begin
          rw++;
        end
      end
    end
  end

  // Monitor: grants push expectations, memory responses pop and compare.
  initial begin
    txn_t t, e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (if_gnt_o && ls_gnt_o) check("gnt_onehot", 32'(if_gnt_o & ls_gnt_o), 32'd0);
        if (if_gnt_o) begin
          check("if_gnt_req", 32'(if_req_i), 32'd1);
          t.is_if = 1; t.we = 0; t.be = 4'hF; t.addr = if_addr_i; t.wdata = 0;
          t.rdata = ref_read(if_addr_i); t.killed = 0;
          sb.push_back(t); grant_log.push_back(1'b1);
          if (if_todo.size() != 0) void'(if_todo.pop_front());
        end else if (ls_gnt_o) begin
          check("ls_gnt_req", 32'(ls_req_i), 32'd1);
          t.is_if = 0; t.we = ls_we_i; t.be = ls_be_i; t.addr = ls_addr_i;
          t.wdata = ls_wdata_i; t.killed = 0; t.rdata = 0;
          if (ls_we_i) ref_mem[ls_addr_i] = merge(ref_read(ls_addr_i), ls_wdata_i, ls_be_i);
          else t.rdata = ref_read(ls_addr_i);
          sb.push_back(t); grant_log.push_back(1'b0);
          if (ls_todo.size() != 0) void'(ls_todo.pop_front());
        end
        if (mem_req_o && sb.size() != 0) begin
          check("mem_addr", mem_addr_o, sb[0].addr);
          check("mem_we", 32'(mem_we_o), 32'(sb[0].we));
          check("mem_be", 32'(mem_be_o), 32'(sb[0].be));
          if (sb[0].we) check("mem_wdata", mem_wdata_o, sb[0].wdata);
        end
        if (mem_rvalid_i) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("if_rvalid", 32'(if_rvalid_o), 32'(e.is_if && !e.killed));
            check("ls_rvalid", 32'(ls_rvalid_o), 32'(!e.is_if));
            if (!e.we) check(e.is_if ? "if_rdata" : "ls_rdata",
                             e.is_if ? if_rdata_o : ls_rdata_o, e.rdata);
          end
        end else if (!tmo_window) begin
          check("rv_spurious", 32'(if_rvalid_o | ls_rvalid_o), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit exp_pat [10];
    bit seen;
    int cnt;
    reset = 1; run = 1; flush_i = 0;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    dev_mem[32'h100] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_gnt", 32'({if_gnt_o, ls_gnt_o}), 32'd0);
    check("rst_rvalid", 32'({if_rvalid_o, ls_rvalid_o}), 32'd0);
    check("rst_mem_fields", {mem_we_o, mem_be_o, mem_addr_o[26:0]}, 32'd0);
    check("rst_error", 32'(error_o), 32'd0);

    sync(); reset = 0;
    sync();
    check("idle_busy", 32'(busy_o), 32'd0);

    // Basic fetch.
    gnt_delay = 1; rsp_delay = 1;
    if_todo.push_back(32'h100);
    drain("t1_drain", 50);

    // Streak limiter with both sides continuously requesting.
    grant_log.delete();
    gnt_delay = 0; rsp_delay = 0;
    for (int i = 0; i < 8; i++) ls_push(1'b0, 4'hF, 32'h3000 + 32'(4 * i), 32'h0);
    if_todo.push_back(32'h400);
    if_todo.push_back(32'h404);
    drain("t2_drain", 300);
    exp_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    check("t2_count", 32'(grant_log.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < grant_log.size()) check("t2_order", 32'(grant_log[i]), 32'(exp_pat[i]));

    // Partial write held until grant, then read back.
    gnt_delay = 3; rsp_delay = 0;
    ls_push(1'b1, 4'b0011, 32'h2000, 32'h0000_1234);
    ls_push(1'b0, 4'hF, 32'h2000, 32'h0);
    drain("t3_drain", 60);

    // Flush during a fetch response.
    gnt_delay = 0; rsp_delay = 4;
    if_todo.push_back(32'h500);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = busy_o && !mem_req_o;
    end
    check("t4_in_rsp", 32'(seen), 32'd1);
    sync(); flush_i = 1;
    if (sb.size() != 0) sb[0].killed = 1'b1;
    sync(); flush_i = 0;
    drain("t4_drain", 40);
    if_todo.push_back(32'h504);
    drain("t4_refetch", 40);

    // Flush must not touch an LSU transaction.
    ls_push(1'b0, 4'hF, 32'h600, 32'h0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = busy_o && !mem_req_o;
    end
    sync(); flush_i = 1;
    sync(); flush_i = 0;
    drain("t4_ls_drain", 40);

    // run=0 while in REQ: finish the transaction, then hold off new grants.
    gnt_delay = 3; rsp_delay = 1;
    ls_push(1'b0, 4'hF, 32'h640, 32'h0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req_o;
    end
    sync(); run = 0;
    if_todo.push_back(32'h700);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !busy_o;
    end
    check("t5_completed", 32'(sb.size()), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("t5_no_gnt", 32'({if_gnt_o, ls_gnt_o}), 32'd0);
      check("t5_idle", 32'(busy_o), 32'd0);
    end
    sync(); run = 1;
    drain("t5_drain", 40);

`ifdef ARB_TIMEOUT_EN
    // Hung memory: watchdog forces a zero response and raises error.
    hang = 1; tmo_window = 1;
    ls_push(1'b0, 4'hF, 32'h800, 32'h0);
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy_o) cnt++;
      if (ls_rvalid_o) begin
        seen = 1;
        check("t6_cycles", 32'(cnt), 32'(TMO));
        check("t6_rdata", ls_rdata_o, 32'h0);
        check("t6_if_rv", 32'(if_rvalid_o), 32'd0);
      end
    end
    check("t6_seen", 32'(seen), 32'd1);
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    check("t6_error", 32'(error_o), 32'd1);
    check("t6_busy", 32'(busy_o), 32'd0);
    hang = 0; tmo_window = 0;
    check("final_error", 32'(error_o), 32'd1);
`else
    check("final_error", 32'(error_o), 32'd0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
